// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage execute unit: ALUop and func codes,
// the decoded internal operation, and the iterative mul/div FSM states.
package alu_pkg;

    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_RTYPE = 2'b10,
        AOP_AND   = 2'b11
    } aluop_e;

    localparam logic [5:0] F_SLL  = 6'b000000, F_SRL   = 6'b000010, F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100, F_SRLV  = 6'b000110, F_SRAV = 6'b000111;
    localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD  = 6'b100000, F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010, F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100, F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110, F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010, F_SLTU  = 6'b101011;

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
        OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO, OP_MUL, OP_DIV, OP_ILL
    } op_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

    typedef struct packed {
        op_e  op;
        logic ovf_en;
        logic sgn;
        logic var_sh;
    } dec_t;

    function automatic dec_t alu_decode(input logic [1:0] alu_op, input logic [5:0] func);
        dec_t d;
        d.op     = OP_ILL;
        d.ovf_en = 1'b0;
        d.sgn    = 1'b0;
        d.var_sh = 1'b0;
        case (aluop_e'(alu_op))
            AOP_ADD: d.op = OP_ADD;
            AOP_SUB: d.op = OP_SUB;
            AOP_AND: d.op = OP_AND;
            default: begin
                case (func)
                    F_ADD:   begin d.op = OP_ADD; d.ovf_en = 1'b1; end
                    F_ADDU:  d.op = OP_ADD;
                    F_SUB:   begin d.op = OP_SUB; d.ovf_en = 1'b1; end
                    F_SUBU:  d.op = OP_SUB;
                    F_AND:   d.op = OP_AND;
                    F_OR:    d.op = OP_OR;
                    F_XOR:   d.op = OP_XOR;
                    F_NOR:   d.op = OP_NOR;
                    F_SLT:   d.op = OP_SLT;
                    F_SLTU:  d.op = OP_SLTU;
                    F_SLL:   d.op = OP_SLL;
                    F_SRL:   d.op = OP_SRL;
                    F_SRA:   d.op = OP_SRA;
                    F_SLLV:  begin d.op = OP_SLL; d.var_sh = 1'b1; end
                    F_SRLV:  begin d.op = OP_SRL; d.var_sh = 1'b1; end
                    F_SRAV:  begin d.op = OP_SRA; d.var_sh = 1'b1; end
                    F_MFHI:  d.op = OP_MFHI;
                    F_MFLO:  d.op = OP_MFLO;
                    F_MULT:  begin d.op = OP_MUL; d.sgn = 1'b1; end
                    F_MULTU: d.op = OP_MUL;
                    F_DIV:   begin d.op = OP_DIV; d.sgn = 1'b1; end
                    F_DIVU:  d.op = OP_DIV;
                    default: d.op = OP_ILL;
                endcase
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_if.sv
// Issue/result bundle between the ID/EX pipeline register and the execute unit.
interface alu_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       alu_op;
    logic [5:0]       func;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             illegal;

    modport master (
        output in_valid, alu_op, func, shamt, src_a, src_b, flush,
        input  in_ready, out_valid, result, zero, overflow, illegal
    );

    modport slave (
        input  in_valid, alu_op, func, shamt, src_a, src_b, flush,
        output in_ready, out_valid, result, zero, overflow, illegal
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply (shift-add) and restoring divide on operand magnitudes,
// one bit per cycle, committing signed-corrected results to HI/LO.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_signed,
    input  logic             i_is_div,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_done_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    state_e             r_state;
    logic [SHW:0]       r_cnt;
    logic [WIDTH-1:0]   r_acc, r_q, r_m, r_a, r_hi, r_lo;
    logic               r_neg_lo, r_neg_hi, r_dz;

    logic [WIDTH:0]     w_add, w_sh;
    logic [WIDTH-1:0]   w_trial, w_acc_n, w_q_n, w_fin_hi, w_fin_lo;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_ge;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? -v : v;
    endfunction

    // MUL: {acc,q} shifts right adding the multiplicand; DIV: {rem,quo} shifts left with trial subtract
    always_comb begin
        w_add   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});
        w_sh    = {r_acc, r_q[WIDTH-1]};
        w_ge    = (w_sh >= {1'b0, r_m});
        w_trial = w_sh[WIDTH-1:0] - r_m;
        if (r_state == S_DIV) begin
            w_acc_n = w_ge ? w_trial : w_sh[WIDTH-1:0];
            w_q_n   = {r_q[WIDTH-2:0], w_ge};
        end else begin
            w_acc_n = w_add[WIDTH:1];
            w_q_n   = {w_add[0], r_q[WIDTH-1:1]};
        end
        w_prod = r_neg_lo ? -{w_acc_n, w_q_n} : {w_acc_n, w_q_n};
        if (r_state == S_DIV) begin
            w_fin_lo = r_dz ? {WIDTH{1'b1}} : (r_neg_lo ? -w_q_n : w_q_n);
            w_fin_hi = r_dz ? r_a : (r_neg_hi ? -w_acc_n : w_acc_n);
        end else begin
            w_fin_lo = w_prod[WIDTH-1:0];
            w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_m      <= '0;
            r_a      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_neg_lo <= 1'b0;
            r_neg_hi <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state  <= i_is_div ? S_DIV : S_MUL;
                    r_cnt    <= (SHW+1)'(WIDTH);
                    r_acc    <= '0;
                    r_q      <= i_is_div ? mag(i_a, i_signed) : mag(i_b, i_signed);
                    r_m      <= i_is_div ? mag(i_b, i_signed) : mag(i_a, i_signed);
                    r_a      <= i_a;
                    r_neg_lo <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
                    r_neg_hi <= i_signed & i_a[WIDTH-1];
                    r_dz     <= (i_b == '0);
                end
                default: if (i_flush) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end else begin
                    r_acc <= w_acc_n;
                    r_q   <= w_q_n;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == (SHW+1)'(1)) begin
                        r_hi    <= w_fin_hi;
                        r_lo    <= w_fin_lo;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_busy    = (r_state != S_IDLE);
    assign o_done    = o_busy && (r_cnt == (SHW+1)'(1)) && !i_flush;
    assign o_done_lo = w_fin_lo;
    assign o_hi      = r_hi;
    assign o_lo      = r_lo;
endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage execute unit: decode, single-cycle datapath and registered outputs;
// multiply/divide is delegated to the iterative unit that owns HI/LO.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);
    dec_t                     w_dec;
    logic                     w_busy, w_ready, w_accept, w_start, w_done;
    logic [WIDTH-1:0]         w_done_lo, w_hi, w_lo, w_res;
    logic [WIDTH:0]           w_sum, w_dif;
    logic [SHW-1:0]           w_shamt;
    logic                     w_ovf, w_ill;
    logic signed [WIDTH-1:0]  w_a_s, w_b_s;
    logic [WIDTH-1:0]         r_result;
    logic                     r_valid, r_zero, r_ovf, r_ill;

    assign w_dec    = alu_decode(bus.alu_op, bus.func);
    assign w_ready  = !w_busy && !bus.flush;
    assign w_accept = bus.in_valid && w_ready;
    assign w_start  = w_accept && (w_dec.op == OP_MUL || w_dec.op == OP_DIV);
    assign w_a_s    = bus.src_a;
    assign w_b_s    = bus.src_b;

    alu_muldiv_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_muldiv (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_start),
        .i_signed  (w_dec.sgn),
        .i_is_div  (w_dec.op == OP_DIV),
        .i_flush   (bus.flush),
        .i_a       (bus.src_a),
        .i_b       (bus.src_b),
        .o_busy    (w_busy),
        .o_done    (w_done),
        .o_done_lo (w_done_lo),
        .o_hi      (w_hi),
        .o_lo      (w_lo)
    );

    // Sign-extended sums expose signed overflow as a mismatch of the top two bits
    always_comb begin
        w_shamt = w_dec.var_sh ? bus.src_a[SHW-1:0] : bus.shamt;
        w_sum   = {bus.src_a[WIDTH-1], bus.src_a} + {bus.src_b[WIDTH-1], bus.src_b};
        w_dif   = {bus.src_a[WIDTH-1], bus.src_a} - {bus.src_b[WIDTH-1], bus.src_b};
        w_res   = '0;
        w_ovf   = 1'b0;
        w_ill   = 1'b0;
        case (w_dec.op)
            OP_ADD:  begin w_res = w_sum[WIDTH-1:0]; w_ovf = w_dec.ovf_en & (w_sum[WIDTH] ^ w_sum[WIDTH-1]); end
            OP_SUB:  begin w_res = w_dif[WIDTH-1:0]; w_ovf = w_dec.ovf_en & (w_dif[WIDTH] ^ w_dif[WIDTH-1]); end
            OP_AND:  w_res = bus.src_a & bus.src_b;
            OP_OR:   w_res = bus.src_a | bus.src_b;
            OP_XOR:  w_res = bus.src_a ^ bus.src_b;
            OP_NOR:  w_res = ~(bus.src_a | bus.src_b);
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.src_a < bus.src_b)};
            OP_SLL:  w_res = bus.src_b << w_shamt;
            OP_SRL:  w_res = bus.src_b >> w_shamt;
            OP_SRA:  w_res = w_b_s >>> w_shamt;
            OP_MFHI: w_res = w_hi;
            OP_MFLO: w_res = w_lo;
            OP_ILL:  begin w_res = bus.src_a & bus.src_b; w_ill = 1'b1; end
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_ill    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_done) begin
                r_valid  <= 1'b1;
                r_result <= w_done_lo;
                r_zero   <= (w_done_lo == '0);
                r_ovf    <= 1'b0;
                r_ill    <= 1'b0;
            end else if (w_accept && !w_start) begin
                r_valid  <= 1'b1;
                r_result <= w_res;
                r_zero   <= (w_res == '0);
                r_ovf    <= w_ovf;
                r_ill    <= w_ill;
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.overflow  = r_ovf;
    assign bus.illegal   = r_ill;
endmodule
